// File: rtl/pt_ring_link_tx_pkg.sv
// Shared types and widths for the ring-stop transmit link.
package pt_ring_link_tx_pkg;
   localparam int LINK_WIDTH = 8;
   localparam int CRD_W      = 4;

   typedef enum logic {
      BYP_PRI   = 1'b0,
      LOC_FORCE = 1'b1
   } arb_st_e;

   typedef struct packed {
      logic                  vld;
      logic [LINK_WIDTH-1:0] dat;
   } link_flit_t;
endpackage

// File: rtl/pt_ring_link_tx_if.sv
// Transmit-side bundle: inject FIFO read port, bypass handshake, outgoing link, credit return.
interface pt_ring_link_tx_if
   import pt_ring_link_tx_pkg::*;
#(
   parameter int WIDTH = LINK_WIDTH
);
   logic             iLocEmpty;
   logic [WIDTH-1:0] iLocDat;
   logic             oLocRdEn;
   logic             iBypVld;
   logic [WIDTH-1:0] iBypDat;
   logic             oBypRdy;
   logic             oLinkVld;
   logic [WIDTH-1:0] oLinkDat;
   logic             iLinkCrd;
   logic [CRD_W-1:0] oCrdCnt;
   logic             oCrdErr;
   logic             oIdle;

   modport master (
      input  iLocEmpty, iLocDat, iBypVld, iBypDat, iLinkCrd,
      output oLocRdEn, oBypRdy, oLinkVld, oLinkDat, oCrdCnt, oCrdErr, oIdle
   );

   modport slave (
      output iLocEmpty, iLocDat, iBypVld, iBypDat, iLinkCrd,
      input  oLocRdEn, oBypRdy, oLinkVld, oLinkDat, oCrdCnt, oCrdErr, oIdle
   );
endinterface

// File: rtl/pt_crd_cnt.sv
// Downstream credit counter: decrement on send, increment on return, saturating at INIT.
module pt_crd_cnt
   import pt_ring_link_tx_pkg::*;
#(
   parameter int INIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iDec,
   input  logic             iInc,
   output logic [CRD_W-1:0] oCnt,
   output logic             oNz,
   output logic             oOvf
);
   localparam logic [CRD_W-1:0] INIT_C = CRD_W'(INIT);

   logic [CRD_W-1:0] cnt;
   logic             ovf;

   // A return with the counter already full is dropped rather than wrapped.
   function automatic logic [CRD_W-1:0] sat_step(input logic [CRD_W-1:0] c,
                                                  input logic dec, input logic inc);
      case ({dec, inc})
         2'b10:   sat_step = c - 1'b1;
         2'b01:   sat_step = (c == INIT_C) ? c : c + 1'b1;
         default: sat_step = c;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= INIT_C;
         ovf <= 1'b0;
      end else begin
         cnt <= sat_step(cnt, iDec, iInc);
         if (iInc && !iDec && (cnt == INIT_C))
            ovf <= 1'b1;
      end
   end

   assign oCnt = cnt;
   assign oNz  = (cnt != '0);
   assign oOvf = ovf;
endmodule

// File: rtl/pt_ring_link_tx.sv
// Ring-stop transmit: merges bypass and local inject traffic onto one credit-controlled link.
module pt_ring_link_tx
   import pt_ring_link_tx_pkg::*;
#(
   parameter int WIDTH      = LINK_WIDTH,
   parameter int CREDITS    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic                clk,
   input logic                rst,
   pt_ring_link_tx_if.master  lk
);
   localparam logic [CRD_W-1:0] CREDITS_C = CRD_W'(CREDITS);
   localparam logic [CRD_W-1:0] STARVE_C  = CRD_W'(STARVE_MAX);

   if (CREDITS < 1 || CREDITS > 15) begin : g_crd_chk
      $error("pt_ring_link_tx: CREDITS must be in 1..15");
   end
   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_chk
      $error("pt_ring_link_tx: STARVE_MAX must be in 1..15");
   end

   arb_st_e          st, st_nxt;
   logic [CRD_W-1:0] starve, starve_nxt;
   logic [CRD_W-1:0] crd;
   logic             crd_nz, crd_ovf;
   logic             can_send, byp_win, loc_win, send;
   logic             vld_p1;
   logic [WIDTH-1:0] dat_p1;

   // Gating with rst keeps both handshakes low throughout reset.
   assign can_send = crd_nz & ~rst;

   always_comb begin
      byp_win    = 1'b0;
      loc_win    = 1'b0;
      st_nxt     = st;
      starve_nxt = starve;
      case (st)
         BYP_PRI: begin
            byp_win = lk.iBypVld;
            loc_win = ~lk.iBypVld & ~lk.iLocEmpty;
            if (can_send) begin
               if (byp_win && !lk.iLocEmpty) begin
                  starve_nxt = starve + 1'b1;
                  if (starve == STARVE_C - 1'b1)
                     st_nxt = LOC_FORCE;
               end else if (loc_win) begin
                  starve_nxt = '0;
               end
            end
         end
         LOC_FORCE: begin
            loc_win = ~lk.iLocEmpty;
            // Leave the forced state even if the FIFO drained underneath us.
            if (can_send) begin
               starve_nxt = '0;
               st_nxt     = BYP_PRI;
            end
         end
         default: st_nxt = BYP_PRI;
      endcase
   end

   assign lk.oBypRdy  = can_send & byp_win;
   assign lk.oLocRdEn = can_send & loc_win & ~lk.iLocEmpty;
   assign send        = lk.oBypRdy | lk.oLocRdEn;

   pt_crd_cnt #(.INIT(CREDITS)) u_crd (
      .clk  (clk),
      .rst  (rst),
      .iDec (send),
      .iInc (lk.iLinkCrd),
      .oCnt (crd),
      .oNz  (crd_nz),
      .oOvf (crd_ovf)
   );

   // Stage p1: registered link flit; data holds while not valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= BYP_PRI;
         starve <= '0;
         vld_p1 <= 1'b0;
         dat_p1 <= '0;
      end else begin
         st     <= st_nxt;
         starve <= starve_nxt;
         vld_p1 <= send;
         if (send)
            dat_p1 <= lk.oBypRdy ? lk.iBypDat : lk.iLocDat;
      end
   end

   assign lk.oLinkVld = vld_p1;
   assign lk.oLinkDat = dat_p1;
   assign lk.oCrdCnt  = crd;
   assign lk.oCrdErr  = crd_ovf;
   assign lk.oIdle    = (crd == CREDITS_C) & ~lk.iBypVld & lk.iLocEmpty & ~vld_p1;
endmodule

// File: tb/tb_pt_ring_link_tx.sv
// Directed and randomized checks of pt_ring_link_tx against a cycle-level behavioural model.
module tb_pt_ring_link_tx;
   import pt_ring_link_tx_pkg::*;

   localparam int CREDITS    = 2;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pt_ring_link_tx_if #(.WIDTH(8)) lk ();

   pt_ring_link_tx #(.WIDTH(8), .CREDITS(CREDITS), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .lk  (lk)
   );

   int n_vec = 0;
   int n_err = 0;

   // Sources: bypass stream and inject FIFO contents (head at index 0).
   logic [7:0] byp_q[$];
   logic [7:0] loc_q[$];
   bit         byp_en = 1'b0;
   logic [7:0] rec[$];

   // Model state: credits, overflow flag, bypass wins against a waiting local flit, link register.
   int         m_crd    = CREDITS;
   bit         m_err    = 1'b0;
   int         m_starve = 0;
   bit         m_vld    = 1'b0;
   logic [7:0] m_dat    = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit auto_ret();
      return (byp_en && byp_q.size() > 0) || loc_q.size() > 0 || m_crd < CREDITS;
   endfunction

   task automatic step(input bit ret);
      bit bv, le, can, forced, eb, el, snd;
      logic [7:0] f;
      @(negedge clk);
      bv = byp_en && byp_q.size() > 0;
      le = (loc_q.size() == 0);
      lk.iBypVld   = bv;
      lk.iBypDat   = bv ? byp_q[0] : 8'h00;
      lk.iLocEmpty = le;
      lk.iLocDat   = le ? 8'h00 : loc_q[0];
      lk.iLinkCrd  = ret;
      #1;
      can    = !rst && m_crd > 0;
      forced = (m_starve >= STARVE_MAX);
      eb     = can && !forced && bv;
      el     = can && !le && (forced || !bv);
      chk("byp_rdy", lk.oBypRdy, eb);
      chk("loc_rden", lk.oLocRdEn, el);
      if (!rst)
         chk("idle", lk.oIdle, (m_crd == CREDITS) && !bv && le && !m_vld);
      snd = eb || el;
      f   = m_dat;
      if (eb)      f = byp_q.pop_front();
      else if (el) f = loc_q.pop_front();
      if (rst) begin
         m_crd = CREDITS; m_err = 1'b0; m_starve = 0; m_vld = 1'b0; m_dat = 8'h00;
      end else begin
         if (can) begin
            if (forced)              m_starve = 0;
            else if (eb && !le)      m_starve++;
            else if (el)             m_starve = 0;
         end
         m_crd = m_crd - int'(snd) + int'(ret);
         if (m_crd > CREDITS) begin
            m_crd = CREDITS;
            m_err = 1'b1;
         end
         m_vld = snd;
         if (snd) m_dat = f;
      end
      @(posedge clk);
      #1;
      chk("link_vld", lk.oLinkVld, m_vld);
      chk("link_dat", lk.oLinkDat, m_dat);
      chk("crd_cnt", lk.oCrdCnt, m_crd);
      chk("crd_err", lk.oCrdErr, m_err);
      if (lk.oLinkVld === 1'b1) rec.push_back(lk.oLinkDat);
   endtask

   initial begin
      logic [7:0] t4_exp[10];
      t4_exp = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h11, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'h12};
      lk.iBypVld = 1'b0; lk.iBypDat = 8'h00; lk.iLocEmpty = 1'b1;
      lk.iLocDat = 8'h00; lk.iLinkCrd = 1'b0;

      // Reset held with both sources offering traffic.
      rst = 1'b1; byp_en = 1'b1;
      byp_q = '{8'hEE}; loc_q = '{8'h77};
      repeat (3) step(1'b0);
      chk("rst_vld", lk.oLinkVld, 1'b0);
      chk("rst_crd", lk.oCrdCnt, 4'd2);
      rst = 1'b0; byp_en = 1'b0;
      byp_q.delete(); loc_q.delete(); rec.delete();

      // Credit stall: third local flit waits for a returned credit.
      loc_q = '{8'h01, 8'h02, 8'h03};
      repeat (4) step(1'b0);
      chk("t2_crd0", lk.oCrdCnt, 4'd0);
      step(1'b1);
      step(1'b0);
      step(1'b0);
      chk("t2_cnt", rec.size(), 3);
      chk("t2_f0", rec[0], 8'h01);
      chk("t2_f1", rec[1], 8'h02);
      chk("t2_f2", rec[2], 8'h03);
      repeat (4) step(auto_ret());

      // Bypass priority over a waiting local flit.
      rec.delete(); byp_en = 1'b1;
      byp_q = '{8'hA0}; loc_q = '{8'h10};
      step(auto_ret());
      chk("t3_first", lk.oLinkDat, 8'hA0);
      repeat (3) step(auto_ret());
      chk("t3_second", rec[1], 8'h10);

      // Starvation guard under continuous bypass.
      rec.delete();
      for (int i = 0; i < 8; i++) byp_q.push_back(8'(8'hB0 + i));
      loc_q = '{8'h11, 8'h12};
      repeat (12) step(auto_ret());
      chk("t4_cnt", rec.size(), 10);
      for (int i = 0; i < 10; i++) chk($sformatf("t4_f%0d", i), rec[i], t4_exp[i]);
      repeat (4) step(auto_ret());

      // Simultaneous send and return, then overflow while idle.
      byp_en = 1'b0;
      loc_q = '{8'h21};
      step(1'b0);
      chk("t5_crd1", lk.oCrdCnt, 4'd1);
      loc_q = '{8'h22};
      step(1'b1);
      chk("t5_same", lk.oCrdCnt, 4'd1);
      step(1'b1);
      chk("t5_noerr", lk.oCrdErr, 1'b0);
      step(1'b1);
      chk("t5_err", lk.oCrdErr, 1'b1);
      chk("t5_sat", lk.oCrdCnt, 4'd2);

      // Reset with credits exhausted and a flit on the link.
      loc_q = '{8'h31, 8'h32, 8'h33};
      step(1'b0);
      step(1'b0);
      chk("t6_pre_crd", lk.oCrdCnt, 4'd0);
      chk("t6_pre_vld", lk.oLinkVld, 1'b1);
      rst = 1'b1;
      step(1'b0);
      chk("t6_vld", lk.oLinkVld, 1'b0);
      chk("t6_crd", lk.oCrdCnt, 4'd2);
      chk("t6_err", lk.oCrdErr, 1'b0);
      rst = 1'b0; loc_q.delete();
      byp_en = 1'b1; byp_q = '{8'hC1}; loc_q = '{8'h41};
      step(auto_ret());
      chk("t6_byp_pri", lk.oLinkDat, 8'hC1);
      repeat (4) step(auto_ret());

      // Randomized traffic, credit returns and occasional resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0 && byp_q.size() < 4) byp_q.push_back(8'($urandom));
         if ($urandom_range(0, 2) == 0 && loc_q.size() < 2) loc_q.push_back(8'($urandom));
         byp_en = ($urandom_range(0, 3) != 0);
         rst    = ($urandom_range(0, 99) == 0);
         step(1'($urandom_range(0, 1)));
      end
      rst = 1'b0; byp_en = 1'b1;
      repeat (20) step(auto_ret());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
